// File: rtl/nios2_camera_sdram_lcd_cpu_oci_dct_packer.sv
// nios2_camera_sdram_lcd_cpu_oci_dct_packer
// Packs 2-bit direct-control-transfer codes into a live buffer/count pair
// and hands completed frames to a one-entry holding register (valid/ready).
// Frames that find the holding register occupied are dropped and flagged
// on the sticky dct_ovf output.
// Optional build macro: DCT_OVF_COUNT_EN adds an 8-bit saturating
// ovf_count output that counts dropped frames.
module nios2_camera_sdram_lcd_cpu_oci_dct_packer #(
    parameter int DCT_DEPTH = 15
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       trc_on,
    input  logic                       dct_valid,
    input  logic [1:0]                 dct_code,
    input  logic                       flush,
    input  logic                       frm_ready,
    input  logic                       ovf_clr,
    output logic [2*DCT_DEPTH-1:0]     dct_buffer,
    output logic [3:0]                 dct_count,
    output logic                       frm_valid,
    output logic [4+2*DCT_DEPTH-1:0]   frm_data,
`ifdef DCT_OVF_COUNT_EN
    output logic [7:0]                 ovf_count,
`endif
    output logic                       dct_ovf
);

    localparam int BW = 2 * DCT_DEPTH;

    logic [BW-1:0]   buffer_reg;
    logic [BW-1:0]   buffer_next;
    logic [3:0]      count_reg;
    logic [3:0]      count_next;
    logic            trc_prev_reg;
    logic            frm_valid_reg;
    logic [BW+3:0]   frm_data_reg;
    logic            ovf_reg;

    logic            absorb;
    logic            trc_fall;
    logic            emit;
    logic            hold_free;
    logic            drop;

    // A code is taken only while tracing; the guard on count keeps the
    // count from ever passing DCT_DEPTH even if the emit path misbehaved.
    assign absorb     = trc_on & dct_valid & (count_reg < 4'(DCT_DEPTH));
    assign count_next = count_reg + {3'd0, absorb};
    assign trc_fall   = trc_prev_reg & ~trc_on;

    // Emission is judged on the post-absorb contents, so a code arriving
    // together with flush or the trace-off edge lands in that frame.
    assign emit = (count_next == 4'(DCT_DEPTH)) |
                  ((flush | trc_fall) & (count_next != 4'd0));

    // The holding slot is usable when empty or when its frame leaves now.
    assign hold_free = ~frm_valid_reg | frm_ready;
    assign drop      = emit & ~hold_free;

    // Each 2-bit slot is overwritten only when it is the current write slot.
    generate
        for (genvar gi = 0; gi < DCT_DEPTH; gi++) begin : g_slot
            assign buffer_next[2*gi +: 2] = (absorb && (count_reg == 4'(gi)))
                                            ? dct_code
                                            : buffer_reg[2*gi +: 2];
        end
    endgenerate

    // Live buffer and count: advance on absorb, restart after any emission.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            buffer_reg   <= '0;
            count_reg    <= '0;
            trc_prev_reg <= 1'b0;
        end else begin
            trc_prev_reg <= trc_on;
            if (emit) begin
                buffer_reg <= '0;
                count_reg  <= '0;
            end else begin
                buffer_reg <= buffer_next;
                count_reg  <= count_next;
            end
        end
    end

    // Holding register: load a new frame when free, otherwise keep the
    // held frame stable; data is left untouched when a frame is accepted.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            frm_valid_reg <= 1'b0;
            frm_data_reg  <= '0;
        end else if (emit && hold_free) begin
            frm_valid_reg <= 1'b1;
            frm_data_reg  <= {count_next, buffer_next};
        end else if (frm_valid_reg && frm_ready) begin
            frm_valid_reg <= 1'b0;
        end
    end

    // Sticky overflow flag; a drop in the same cycle beats the clear.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ovf_reg <= 1'b0;
        end else if (drop) begin
            ovf_reg <= 1'b1;
        end else if (ovf_clr) begin
            ovf_reg <= 1'b0;
        end
    end

`ifdef DCT_OVF_COUNT_EN
    logic [7:0] ovf_count_reg;

    // Saturating dropped-frame counter; clear plus drop restarts at one.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ovf_count_reg <= 8'd0;
        end else if (drop) begin
            if (ovf_clr) begin
                ovf_count_reg <= 8'd1;
            end else if (ovf_count_reg != 8'hFF) begin
                ovf_count_reg <= ovf_count_reg + 8'd1;
            end
        end else if (ovf_clr) begin
            ovf_count_reg <= 8'd0;
        end
    end

    assign ovf_count = ovf_count_reg;
`endif

    assign dct_buffer = buffer_reg;
    assign dct_count  = count_reg;
    assign frm_valid  = frm_valid_reg;
    assign frm_data   = frm_data_reg;
    assign dct_ovf    = ovf_reg;

endmodule

// File: tb/tb_nios2_camera_sdram_lcd_cpu_oci_dct_packer.sv
// Directed testbench for nios2_camera_sdram_lcd_cpu_oci_dct_packer.
// Expected values are hand-computed constants; one line per transaction.
// Build with +define+DCT_OVF_COUNT_EN to also cover ovf_count.
module tb_nios2_camera_sdram_lcd_cpu_oci_dct_packer;

    logic        clk;
    logic        reset_n;
    logic        trc_on;
    logic        dct_valid;
    logic [1:0]  dct_code;
    logic        flush;
    logic        frm_ready;
    logic        ovf_clr;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        frm_valid;
    logic [33:0] frm_data;
    logic        dct_ovf;
`ifdef DCT_OVF_COUNT_EN
    logic [7:0]  ovf_count;
`endif

    int checks;
    int errors;

    nios2_camera_sdram_lcd_cpu_oci_dct_packer #(.DCT_DEPTH(15)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .trc_on     (trc_on),
        .dct_valid  (dct_valid),
        .dct_code   (dct_code),
        .flush      (flush),
        .frm_ready  (frm_ready),
        .ovf_clr    (ovf_clr),
        .dct_buffer (dct_buffer),
        .dct_count  (dct_count),
        .frm_valid  (frm_valid),
        .frm_data   (frm_data),
`ifdef DCT_OVF_COUNT_EN
        .ovf_count  (ovf_count),
`endif
        .dct_ovf    (dct_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts and reports.
    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present the same code for n consecutive cycles.
    task automatic feed(input logic [1:0] code, input int n);
        dct_valid = 1'b1;
        dct_code  = code;
        for (int i = 0; i < n; i++) step();
        dct_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset_n   = 1'b0;
        trc_on    = 1'b0;
        dct_valid = 1'b0;
        dct_code  = 2'b00;
        flush     = 1'b0;
        frm_ready = 1'b0;
        ovf_clr   = 1'b0;

        // Reset state
        step();
        check_val("rst_count", 64'(dct_count), 64'd0);
        check_val("rst_buffer", 64'(dct_buffer), 64'd0);
        check_val("rst_frm_valid", 64'(frm_valid), 64'd0);
        check_val("rst_ovf", 64'(dct_ovf), 64'd0);
        reset_n = 1'b1;
        trc_on  = 1'b1;

        // Three codes 01,10,11 -> 0x39
        feed(2'b01, 1);
        check_val("one_code_count", 64'(dct_count), 64'd1);
        feed(2'b10, 1);
        feed(2'b11, 1);
        check_val("three_count", 64'(dct_count), 64'd3);
        check_val("three_buffer", 64'(dct_buffer), 64'h39);
        check_val("three_frm_valid", 64'(frm_valid), 64'd0);

        // Full frame of fifteen 10 codes
        do_reset();
        frm_ready = 1'b1;
        feed(2'b10, 14);
        check_val("fill14_count", 64'(dct_count), 64'd14);
        check_val("fill14_frm_valid", 64'(frm_valid), 64'd0);
        feed(2'b10, 1);
        check_val("full_frm_valid", 64'(frm_valid), 64'd1);
        check_val("full_frm_data", 64'(frm_data), {30'd0, 4'hF, 30'h2AAAAAAA});
        check_val("full_count", 64'(dct_count), 64'd0);
        check_val("full_buffer", 64'(dct_buffer), 64'd0);
        step();
        check_val("accept_frm_valid", 64'(frm_valid), 64'd0);
        check_val("accept_frm_hold", 64'(frm_data), {30'd0, 4'hF, 30'h2AAAAAAA});

        // Flush with a code in the same cycle, then flush while empty
        frm_ready = 1'b0;
        feed(2'b01, 2);
        flush = 1'b1;
        feed(2'b11, 1);
        flush = 1'b0;
        check_val("flush_frm_valid", 64'(frm_valid), 64'd1);
        check_val("flush_frm_data", 64'(frm_data), {30'd0, 4'h3, 30'h35});
        check_val("flush_count", 64'(dct_count), 64'd0);
        frm_ready = 1'b1;
        flush     = 1'b1;
        step();
        flush = 1'b0;
        check_val("empty_flush_valid", 64'(frm_valid), 64'd0);
        check_val("empty_flush_ovf", 64'(dct_ovf), 64'd0);

        // Held frame stalls; second full frame is dropped
        frm_ready = 1'b0;
        feed(2'b01, 15);
        check_val("held_frm_data", 64'(frm_data), {30'd0, 4'hF, 30'h15555555});
        feed(2'b11, 15);
        check_val("drop_frm_valid", 64'(frm_valid), 64'd1);
        check_val("drop_frm_data", 64'(frm_data), {30'd0, 4'hF, 30'h15555555});
        check_val("drop_ovf", 64'(dct_ovf), 64'd1);
        check_val("drop_count", 64'(dct_count), 64'd0);
`ifdef DCT_OVF_COUNT_EN
        check_val("drop_ovf_count", 64'(ovf_count), 64'd1);
`endif
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        check_val("clr_ovf", 64'(dct_ovf), 64'd0);
`ifdef DCT_OVF_COUNT_EN
        check_val("clr_ovf_count", 64'(ovf_count), 64'd0);
`endif
        // Drop and clear in the same cycle: drop wins
        feed(2'b10, 14);
        ovf_clr = 1'b1;
        feed(2'b10, 1);
        ovf_clr = 1'b0;
        check_val("drop_vs_clr_ovf", 64'(dct_ovf), 64'd1);
`ifdef DCT_OVF_COUNT_EN
        check_val("drop_vs_clr_count", 64'(ovf_count), 64'd1);
`endif
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;

        // Holding full but accepted in the emit cycle: replaced, no overflow
        feed(2'b00, 14);
        frm_ready = 1'b1;
        feed(2'b00, 1);
        check_val("pass_frm_valid", 64'(frm_valid), 64'd1);
        check_val("pass_frm_data", 64'(frm_data), {30'd0, 4'hF, 30'h0});
        check_val("pass_ovf", 64'(dct_ovf), 64'd0);
        step();

        // Trace turned off with four codes pending
        dct_valid = 1'b1;
        dct_code  = 2'b01; step();
        dct_code  = 2'b10; step();
        dct_code  = 2'b11; step();
        dct_code  = 2'b00; step();
        check_val("pre_off_count", 64'(dct_count), 64'd4);
        trc_on   = 1'b0;
        dct_code = 2'b11;
        step();
        check_val("off_frm_valid", 64'(frm_valid), 64'd1);
        check_val("off_frm_data", 64'(frm_data), {30'd0, 4'h4, 30'h39});
        check_val("off_count", 64'(dct_count), 64'd0);
        step();
        step();
        dct_valid = 1'b0;
        check_val("ignored_count", 64'(dct_count), 64'd0);
        check_val("ignored_buffer", 64'(dct_buffer), 64'd0);

        // Reset mid-frame with a held frame
        trc_on    = 1'b1;
        frm_ready = 1'b0;
        flush     = 1'b1;
        feed(2'b10, 1);
        flush = 1'b0;
        feed(2'b11, 7);
        check_val("mid_count", 64'(dct_count), 64'd7);
        check_val("mid_frm_valid", 64'(frm_valid), 64'd1);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        check_val("mid_rst_count", 64'(dct_count), 64'd0);
        check_val("mid_rst_buffer", 64'(dct_buffer), 64'd0);
        check_val("mid_rst_frm_valid", 64'(frm_valid), 64'd0);
        check_val("mid_rst_frm_data", 64'(frm_data), 64'd0);
        check_val("mid_rst_ovf", 64'(dct_ovf), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
